// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encodings, decode field ranges,
// default reset PC and the prefetch buffer entry layout.
package ifetch_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int OP_FIELD_HI    = 31;
  localparam int OP_FIELD_LO    = 26;
  localparam int FUNCT_FIELD_HI = 5;
  localparam int FUNCT_FIELD_LO = 0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer holding {pc, inst} pairs; clear has priority over push and pop.
import ifetch_pkg::*;

module ifetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (push && !clear && wr_ptr_reg == AW'(gi)) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC, credit-limited in-order memory reads, prefetch buffer and
// redirect flushing. Optional misaligned-redirect trap enabled by IFETCH_ALIGN_CHECK_EN.
import ifetch_pkg::*;

module ifetch_unit #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_gnt,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        fetch_exc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [CW-1:0] drop_reg, drop_next;
  logic          exc_reg, exc_next;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_data;
  logic [CW:0]   credit_used;
  logic [31:0]   target_pc;
  logic          redir, issue, fire, ret, push, pop;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target_pc = redirect_pc;
  assign exc_next  = exc_reg | (redir && (redirect_pc[1:0] != 2'b00));
`else
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;
  assign exc_next  = 1'b0;
`endif

  always_comb begin
    redir       = redirect && (state_reg != ST_BOOT);
    credit_used = {1'b0, inflight_reg} + {1'b0, fifo_count};
    issue       = (state_reg == ST_RUN) && !exc_reg && (credit_used < (CW+1)'(DEPTH));
    fire        = issue && imem_gnt;
    // A response with nothing outstanding (e.g. stray beat after reset) is ignored outright.
    ret         = imem_rvalid && (inflight_reg != '0);
    push        = ret && (drop_reg == '0) && !redir;
    pop         = inst_valid && inst_ready && !redir;

    inflight_next = inflight_reg + CW'(fire) - CW'(ret);

    drop_next = drop_reg;
    if (redir) begin
      drop_next = inflight_next;
    end else if (ret && (drop_reg != '0)) begin
      drop_next = drop_reg - CW'(1);
    end

    pc_next = pc_reg;
    if (redir) begin
      pc_next = target_pc;
    end else if (fire) begin
      pc_next = pc_reg + 32'd4;
    end

    state_next = state_reg;
    case (state_reg)
      ST_BOOT:  state_next = ST_RUN;
      ST_RUN:   if (redir && (inflight_next != '0)) state_next = ST_FLUSH;
      ST_FLUSH: if (!redir && (drop_next == '0)) state_next = ST_RUN;
      default:  state_next = ST_BOOT;
    endcase
  end

  // The oldest non-dropped response belongs to the address inflight words behind pc.
  assign push_data.pc   = pc_reg - (32'(inflight_reg) << 2);
  assign push_data.inst = imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_BOOT;
      pc_reg       <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
      exc_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
      exc_reg      <= exc_next;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redir),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign imem_req   = issue;
  assign imem_addr  = pc_reg;
  assign inst_valid = !fifo_empty && (state_reg == ST_RUN);
  assign inst       = fifo_empty ? 32'h0 : fifo_head.inst;
  assign inst_pc    = fifo_empty ? 32'h0 : fifo_head.pc;
  assign op         = inst[OP_FIELD_HI:OP_FIELD_LO];
  assign funct      = inst[FUNCT_FIELD_HI:FUNCT_FIELD_LO];
  assign fetch_exc  = exc_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit (DEPTH=2); the misaligned step follows IFETCH_ALIGN_CHECK_EN.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic        imem_gnt;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        fetch_exc;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_gnt    (imem_gnt),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .op          (op),
    .funct       (funct),
    .fetch_exc   (fetch_exc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F11;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs change 1ns after the rising edge, outputs are checked 1ns later.
  task automatic win(input logic g, input logic rv, input logic [31:0] ra, input logic rdy,
                     input logic red, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rv ? word(ra) : 32'h0;
    inst_ready  = rdy;
    redirect    = red;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic chk_inst(input string tag, input logic [31:0] pc);
    logic [31:0] w;
    w = word(pc);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_pc"}, inst_pc, pc);
    chk({tag, "_inst"}, inst, w);
    chk({tag, "_op"}, 32'(op), 32'(w[31:26]));
    chk({tag, "_funct"}, 32'(funct), 32'(w[5:0]));
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, "_req"}, 32'(imem_req), 32'(r));
    if (r) chk({tag, "_addr"}, imem_addr, a);
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_exc", 32'(fetch_exc), 32'd0);
    // Boot cycle: no request yet.
    rst_n = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;
    #1;
    chk_req("boot", 1'b0, 32'h0);

    // 1: streaming with gnt=1, rvalid one cycle after grant, ready=1.
    for (int k = 0; k < 3; k++) begin
      logic [31:0] b;
      b = 32'(8 * k);
      win(1, 0, 0, 1, 0, 0);
      chk_req("t1_a", 1'b1, b);
      if (k == 0) chk("t1_a_valid", 32'(inst_valid), 32'd0);
      else chk_inst("t1_a", b - 32'd4);
      win(1, 1, b, 1, 0, 0);
      chk_req("t1_b", 1'b1, b + 32'd4);
      chk("t1_b_valid", 32'(inst_valid), 32'd0);
      win(1, 1, b + 32'd4, 1, 0, 0);
      chk_req("t1_c", 1'b0, 32'h0);
      chk_inst("t1_c", b);
    end

    // 2: backpressure; credits cap requests, head held, nothing lost.
    win(1, 0, 0, 0, 0, 0);
    chk_req("t2_a", 1'b1, 32'd24);
    chk_inst("t2_a", 32'd20);
    win(1, 1, 32'd24, 0, 0, 0);
    chk_req("t2_b", 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      win(1, 0, 0, 0, 0, 0);
      chk_req("t2_hold", 1'b0, 32'h0);
      chk("t2_hold_pc", inst_pc, 32'd20);
    end
    win(1, 0, 0, 1, 0, 0);
    chk_req("t2_c", 1'b0, 32'h0);
    chk_inst("t2_c", 32'd20);
    win(1, 0, 0, 1, 0, 0);
    chk_req("t2_d", 1'b1, 32'd28);
    chk_inst("t2_d", 32'd24);

    // 3: two in flight, redirect to 0x100; both returns dropped.
    win(1, 0, 0, 1, 0, 0);
    chk_req("t3_a", 1'b1, 32'd32);
    win(0, 0, 0, 1, 1, 32'h100);
    chk_req("t3_redir", 1'b0, 32'h0);
    win(0, 1, 32'd28, 1, 0, 0);
    chk_req("t3_drop0", 1'b0, 32'h0);
    chk("t3_drop0_valid", 32'(inst_valid), 32'd0);
    win(0, 1, 32'd32, 1, 0, 0);
    chk_req("t3_drop1", 1'b0, 32'h0);
    win(1, 0, 0, 1, 0, 0);
    chk_req("t3_b", 1'b1, 32'h100);
    chk("t3_b_valid", 32'(inst_valid), 32'd0);
    win(1, 1, 32'h100, 1, 0, 0);
    chk_req("t3_c", 1'b1, 32'h104);
    win(0, 1, 32'h104, 1, 0, 0);
    chk_req("t3_d", 1'b0, 32'h0);
    chk_inst("t3_d", 32'h100);

    // 4: redirect in the same cycle as a grant and a kept-looking return.
    win(1, 0, 0, 1, 0, 0);
    chk_req("t4_a", 1'b1, 32'h108);
    chk_inst("t4_a", 32'h104);
    win(1, 1, 32'h108, 1, 1, 32'h200);
    chk_req("t4_redir", 1'b1, 32'h10C);
    chk("t4_redir_valid", 32'(inst_valid), 32'd0);
    win(0, 1, 32'h10C, 1, 0, 0);
    chk_req("t4_flush", 1'b0, 32'h0);
    win(1, 0, 0, 1, 0, 0);
    chk_req("t4_b", 1'b1, 32'h200);
    chk("t4_b_valid", 32'(inst_valid), 32'd0);
    win(0, 1, 32'h200, 1, 0, 0);
    chk_req("t4_c", 1'b1, 32'h204);
    win(0, 0, 0, 1, 0, 0);
    chk_req("t4_d", 1'b1, 32'h204);
    chk_inst("t4_d", 32'h200);

    // 5: PC wraps from 0xFFFF_FFFC to 0.
    win(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk_req("t5_redir", 1'b1, 32'h204);
    win(1, 0, 0, 1, 0, 0);
    chk_req("t5_a", 1'b1, 32'hFFFF_FFFC);
    win(0, 1, 32'hFFFF_FFFC, 1, 0, 0);
    chk_req("t5_wrap", 1'b1, 32'h0);
    win(0, 0, 0, 1, 0, 0);
    chk_inst("t5_b", 32'hFFFF_FFFC);

    // 6: misaligned redirect target.
    win(0, 0, 0, 1, 1, 32'h102);
    chk("t6_redir_valid", 32'(inst_valid), 32'd0);
    win(1, 0, 0, 1, 0, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk_req("t6_a", 1'b0, 32'h0);
    chk("t6_a_exc", 32'(fetch_exc), 32'd1);
    win(0, 0, 0, 1, 0, 0);
    chk_req("t6_b", 1'b0, 32'h0);
    chk("t6_b_exc", 32'(fetch_exc), 32'd1);
`else
    chk_req("t6_a", 1'b1, 32'h100);
    chk("t6_a_exc", 32'(fetch_exc), 32'd0);
    win(0, 0, 0, 1, 0, 0);
    chk_req("t6_b", 1'b1, 32'h104);
    chk("t6_b_exc", 32'(fetch_exc), 32'd0);
`endif

    // Asynchronous reset mid-transfer, then a stray response is ignored.
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(imem_req), 32'd0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_valid", 32'(inst_valid), 32'd0);
    chk("ar_exc", 32'(fetch_exc), 32'd0);
    win(0, 1, 32'h104, 1, 0, 0);
    rst_n = 1'b1;
    #1;
    chk_req("ar_boot", 1'b0, 32'h0);
    win(0, 1, 32'h104, 1, 0, 0);
    chk_req("ar_run", 1'b1, 32'h0);
    chk("ar_run_valid", 32'(inst_valid), 32'd0);
    win(0, 0, 0, 1, 0, 0);
    chk("ar_stray_valid", 32'(inst_valid), 32'd0);
    chk_req("ar_end", 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
